// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer in front of the CSR unit.
// It prioritises interrupts, synchronous exceptions and mret. It then drives
// the CSR strobes and redirects and flushes the fetch path.
// Optional feature macro: TRAP_VECTORED_EN. When it is defined, interrupts use
// vectored mtvec mode (mtvec[1:0]==2'b01).
module trap_ctrl #(
    parameter int MTVEC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        illegal_instr,
    input  logic        misaligned_fetch,
    input  logic        mret,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        trap_enter,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_cause,
    output logic        mret_exec,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        stall,
    output logic        mip_mtip,
    output logic        mip_meip
);

    typedef enum logic [1:0] {IDLE, ENTER, VECTOR, RETURN} state_t;

    localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MISALIGN  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] BASE_MASK       = ~((32'h1 << MTVEC_ALIGN) - 32'h1);

    state_t      state_q, state_d;
    logic [1:0]  mtip_sync, meip_sync;
    logic [31:0] pc_q, cause_q;
    logic        irq_take, exc_take, trap_take, mret_take;
    logic [31:0] cause_sel;
    logic [31:0] vec_base, vec_pc;

    assign mip_mtip   = mtip_sync[1];
    assign mip_meip   = meip_sync[1];
    assign trap_pc    = pc_q;
    assign trap_cause = cause_q;

    // Two-flop synchronisers for the asynchronous interrupt levels.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip_sync <= 2'b00;
            meip_sync <= 2'b00;
        end else begin
            mtip_sync <= {mtip_sync[0], irq_timer};
            meip_sync <= {meip_sync[0], irq_ext};
        end
    end

    // Event detection and cause priority: interrupts first, then exceptions.
    // mret loses to any exception on the same instruction.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        irq_take  = instr_valid & mstatus_mie &
                    ((mip_meip & mie_meie) | (mip_mtip & mie_mtie));
        exc_take  = instr_valid & (misaligned_fetch | illegal_instr | ebreak | ecall);
        trap_take = irq_take | exc_take;
        mret_take = instr_valid & mret & ~trap_take;
        cause_sel = CAUSE_ECALL;
        if (irq_take && mip_meip && mie_meie) cause_sel = CAUSE_EXT_IRQ;
        else if (irq_take)                    cause_sel = CAUSE_TIMER_IRQ;
        else if (misaligned_fetch)            cause_sel = CAUSE_MISALIGN;
        else if (illegal_instr)               cause_sel = CAUSE_ILLEGAL;
        else if (ebreak)                      cause_sel = CAUSE_EBREAK;
    end

    // Trap vector target. Vectored mode applies to interrupts only.
    always_comb begin
        vec_base = mtvec_in & BASE_MASK;
`ifdef TRAP_VECTORED_EN
        if (mtvec_in[1:0] == 2'b01 && cause_q[31])
            vec_pc = vec_base + {cause_q[29:0], 2'b00};
        else
            vec_pc = vec_base;
`else
        vec_pc = vec_base;
`endif
    end

    // State register plus the pc and cause captured when the trap is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && trap_take) begin
                pc_q    <= pc;
                cause_q <= cause_sel;
            end
        end
    end

    // Next state and Moore strobes; decoder flags only matter in IDLE.
    always_comb begin
        state_d        = state_q;
        trap_enter     = 1'b0;
        mret_exec      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        flush          = 1'b0;
        stall          = 1'b1;
        unique case (state_q)
            IDLE: begin
                stall = trap_take | mret_take;
                if (trap_take)      state_d = ENTER;
                else if (mret_take) state_d = RETURN;
            end
            ENTER: begin
                trap_enter = 1'b1;
                state_d    = VECTOR;
            end
            VECTOR: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                redirect_pc    = vec_pc;
                state_d        = IDLE;
            end
            RETURN: begin
                mret_exec      = 1'b1;
                redirect_valid = 1'b1;
                flush          = 1'b1;
                redirect_pc    = mepc_in;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl. Stimulus pushes the expected
// trap or mret outcome into a queue. A negedge monitor pops it and compares
// when the DUT strobes.
module tb_trap_ctrl;

    typedef struct {
        logic        is_mret;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] target;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, ecall, ebreak, illegal_instr, misaligned_fetch, mret;
    logic [31:0] pc, mtvec_in, mepc_in;
    logic        mstatus_mie, mie_mtie, mie_meie, irq_timer, irq_ext;
    logic        trap_enter, mret_exec, redirect_valid, flush, stall, mip_mtip, mip_meip;
    logic [31:0] trap_pc, trap_cause, redirect_pc;

    exp_t exp_q[$];
    exp_t pend_item;
    logic pend = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   redirect_count = 0;

    trap_ctrl #(.MTVEC_ALIGN(2)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
        .ecall(ecall), .ebreak(ebreak), .illegal_instr(illegal_instr),
        .misaligned_fetch(misaligned_fetch), .mret(mret),
        .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
        .irq_timer(irq_timer), .irq_ext(irq_ext),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .trap_enter(trap_enter), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_exec(mret_exec), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
        .mip_mtip(mip_mtip), .mip_meip(mip_meip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: highest-priority outcome of one instruction, straight
    // from the cause table. Returns 0 when the instruction causes nothing.
    function automatic logic model(input logic [31:0] ipc, input logic [4:0] f,
                                   input logic [31:0] mepc_final, output exp_t e);
        logic ext_ok, tim_ok;
        logic [31:0] base;
        ext_ok = mstatus_mie && irq_ext && mie_meie;
        tim_ok = mstatus_mie && irq_timer && mie_mtie;
        base   = {mtvec_in[31:2], 2'b00};
        e.is_mret = 1'b0;
        e.pc      = ipc;
        e.cyc     = cyc;
        e.target  = base;
        if (ext_ok)         e.cause = 32'h8000_000B;
        else if (tim_ok)    e.cause = 32'h8000_0007;
        else if (f[4])      e.cause = 0;
        else if (f[3])      e.cause = 2;
        else if (f[2])      e.cause = 3;
        else if (f[1])      e.cause = 11;
        else if (f[0]) begin
            e.is_mret = 1'b1;
            e.cause   = 0;
            e.target  = mepc_final;
            return 1'b1;
        end else return 1'b0;
`ifdef TRAP_VECTORED_EN
        if (e.cause[31] && mtvec_in[1:0] == 2'b01) e.target = base + 4 * (e.cause & 32'h7FFF_FFFF);
`endif
        return 1'b1;
    endfunction

    // Monitor: pops the scoreboard on each strobe and checks the follow-up redirect.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (redirect_valid) redirect_count++;
            if (pend) begin
                check("trap_redirect_valid", redirect_valid, 1);
                check("trap_flush", flush, 1);
                check("trap_no_mret_exec", mret_exec, 0);
                check("trap_redirect_pc", redirect_pc, pend_item.target);
                pend = 1'b0;
            end else if (redirect_valid || mret_exec || flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_redirect", {redirect_valid, mret_exec, flush}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mret_kind", {31'b0, e.is_mret}, 1);
                    check("mret_exec", mret_exec, 1);
                    check("mret_flush", flush, 1);
                    check("mret_redirect_valid", redirect_valid, 1);
                    check("mret_redirect_pc", redirect_pc, e.target);
                    check("mret_latency", cyc, e.cyc + 1);
                end
            end
            if (trap_enter) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_trap_enter", trap_enter, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("trap_kind", {31'b0, e.is_mret}, 0);
                    check("trap_pc", trap_pc, e.pc);
                    check("trap_cause", trap_cause, e.cause);
                    check("trap_latency", cyc, e.cyc + 1);
                    pend_item = e;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One valid instruction for one cycle, then enough idle cycles to return to IDLE.
    // mepc_in changes on the RETURN cycle, so only the value sampled there is correct.
    task automatic issue(input logic [31:0] ipc, input logic [4:0] f, input logic [31:0] mepc_final);
        exp_t e;
        logic ev;
        ev = model(ipc, f, mepc_final, e);
        if (ev) exp_q.push_back(e);
        pc = ipc;
        {misaligned_fetch, illegal_instr, ebreak, ecall, mret} = f;
        instr_valid = 1'b1;
        mepc_in = ~mepc_final;
        @(negedge clk);
        check("stall_on_issue", stall, ev);
        tick(1);
        instr_valid = 1'b0;
        {misaligned_fetch, illegal_instr, ebreak, ecall, mret} = 5'b0;
        mepc_in = mepc_final;
        tick(4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobes"}, {trap_enter, mret_exec, redirect_valid, flush, stall}, 0);
        check({tag, "_trap_pc"}, trap_pc, 0);
        check({tag, "_trap_cause"}, trap_cause, 0);
        check({tag, "_redirect_pc"}, redirect_pc, 0);
    endtask

    initial begin
        int rc0;
        rst = 1'b1;
        {instr_valid, ecall, ebreak, illegal_instr, misaligned_fetch, mret} = 6'b0;
        {mstatus_mie, mie_mtie, mie_meie, irq_timer} = 4'b0;
        irq_ext = 1'b1;
        pc = 0; mtvec_in = 32'h100; mepc_in = 0;
        tick(3);
        check_outputs_zero("reset");
        check("reset_mip", {mip_mtip, mip_meip}, 0);
        irq_ext = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // ecall, then simultaneous illegal_instr + ebreak (cause 2 wins)
        issue(32'h40, 5'b00010, 0);
        issue(32'h80, 5'b01100, 0);

        // timer interrupt through the synchroniser, possibly vectored
        mtvec_in = 32'h101; mstatus_mie = 1; mie_mtie = 1;
        irq_timer = 1;
        @(negedge clk);
        tick(1);
        @(negedge clk);
        check("mtip_after_1_edge", mip_mtip, 0);
        tick(1);
        @(negedge clk);
        check("mtip_after_2_edges", mip_mtip, 1);
        tick(1);
        issue(32'h300, 5'b00000, 0);
        irq_timer = 0; mie_mtie = 0; mtvec_in = 32'h100;
        tick(4);

        // masked external interrupt, then unmasked
        irq_ext = 1; mstatus_mie = 0; mie_meie = 0;
        tick(4);
        check("meip_pending_masked", mip_meip, 1);
        issue(32'h400, 5'b00000, 0);
        mie_meie = 1; mstatus_mie = 1;
        issue(32'h404, 5'b00000, 0);
        irq_ext = 0; mie_meie = 0; mstatus_mie = 0;
        tick(4);

        // mret honours mepc_in as seen in RETURN
        issue(32'h500, 5'b00001, 32'h2000);

        // reset while in ENTER: outputs clear at once and no redirect follows
        pc = 32'h600; ecall = 1; instr_valid = 1;
        tick(1);
        instr_valid = 0; ecall = 0;
        rst = 1;
        #1;
        check_outputs_zero("midseq_reset");
        rc0 = redirect_count;
        tick(2);
        rst = 0;
        tick(5);
        check("no_redirect_after_reset", redirect_count, rc0);
        issue(32'h640, 5'b00010, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            logic [4:0] f;
            mtvec_in    = {$urandom_range(0, 32'hFFFF), 14'b0, 2'($urandom_range(0, 3))};
            mstatus_mie = 1'($urandom_range(0, 1));
            mie_mtie    = 1'($urandom_range(0, 1));
            mie_meie    = 1'($urandom_range(0, 1));
            irq_timer   = ($urandom_range(0, 3) == 0);
            irq_ext     = ($urandom_range(0, 4) == 0);
            tick(4);
            for (int b = 0; b < 5; b++) f[b] = ($urandom_range(0, 3) == 0);
            issue({$urandom(), 2'b00} , f, {$urandom_range(0, 32'hFFFF), 2'b00});
        end
        irq_timer = 0; irq_ext = 0;
        tick(4);

        check("scoreboard_drained", exp_q.size(), 0);
        check("no_pending_redirect", {31'b0, pend}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
